// File: rtl/dual_issue_scheduler.sv
`timescale 1ns/1ps
// dual_issue_scheduler
// Issue controller between IF/ID and ID/EX for a two-lane pipeline.
// Each cycle it issues both lanes, issues lane 1 and leaves lane 2 pending,
// issues the pending lane 2, or stalls. It also keeps saturating
// performance counters for stalls, split pairs and dual issues.
module dual_issue_scheduler #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             in_valid_2,
  output logic             in_ready,
  input  logic [4:0]       rs1_1,
  input  logic [4:0]       rs2_1,
  input  logic [4:0]       rd_1,
  input  logic             we_1,
  input  logic             mem_1,
  input  logic             br_1,
  input  logic [4:0]       rs1_2,
  input  logic [4:0]       rs2_2,
  input  logic [4:0]       rd_2,
  input  logic             we_2,
  input  logic             mem_2,
  input  logic [4:0]       ex_rd_1,
  input  logic [4:0]       ex_rd_2,
  input  logic             ex_load_1,
  input  logic             ex_load_2,
  input  logic             ex_hold,
  input  logic             flush,
  output logic             iss_1,
  output logic             iss_2,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] split_cnt,
  output logic [CNT_W-1:0] dual_cnt
);

  // S_HALF means lane 1 of the current pair is already in ID/EX.
  typedef enum logic {
    S_PAIR = 1'b0,
    S_HALF = 1'b1
  } state_t;

  state_t state;
  state_t state_next;

  logic haz_1;
  logic haz_2;
  logic raw;
  logic split;
  logic stall_inc;
  logic split_inc;
  logic dual_inc;

  // Lane-2 destination never creates a hazard: lane 2 is younger, so WAW
  // is resolved by forwarding priority rather than by the scheduler.
  logic unused_lane2_dest;
  assign unused_lane2_dest = ^{rd_2, we_2};

  // A source register that an in-flight load in ID/EX has not produced yet.
  function automatic logic lu(input logic [4:0] rs,
                              input logic [4:0] erd1, input logic el1,
                              input logic [4:0] erd2, input logic el2);
    return (rs != 5'd0) && (((rs == erd1) && el1) || ((rs == erd2) && el2));
  endfunction

  assign haz_1 = lu(rs1_1, ex_rd_1, ex_load_1, ex_rd_2, ex_load_2) |
                 lu(rs2_1, ex_rd_1, ex_load_1, ex_rd_2, ex_load_2);
  assign haz_2 = lu(rs1_2, ex_rd_1, ex_load_1, ex_rd_2, ex_load_2) |
                 lu(rs2_2, ex_rd_1, ex_load_1, ex_rd_2, ex_load_2);
  assign raw   = we_1 && (rd_1 != 5'd0) && ((rs1_2 == rd_1) || (rs2_2 == rd_1));
  assign split = raw | (mem_1 & mem_2) | br_1;

  // Issue decision and next state; flush beats hold beats normal issue.
  always_comb begin
    iss_1      = 1'b0;
    iss_2      = 1'b0;
    in_ready   = 1'b0;
    state_next = state;
    stall_inc  = 1'b0;
    split_inc  = 1'b0;
    dual_inc   = 1'b0;
    if (!rst_n) begin
      state_next = S_PAIR;
    end else if (flush) begin
      in_ready   = 1'b1;
      state_next = S_PAIR;
    end else if (ex_hold) begin
      state_next = state;
    end else begin
      case (state)
        S_PAIR: begin
          if (in_valid) begin
            if (haz_1) begin
              stall_inc = 1'b1;
            end else if (!in_valid_2) begin
              iss_1    = 1'b1;
              in_ready = 1'b1;
            end else if (split | haz_2) begin
              iss_1      = 1'b1;
              state_next = S_HALF;
              split_inc  = 1'b1;
            end else begin
              iss_1    = 1'b1;
              iss_2    = 1'b1;
              in_ready = 1'b1;
              dual_inc = 1'b1;
            end
          end
        end
        S_HALF: begin
          if (in_valid) begin
            if (haz_2) begin
              stall_inc = 1'b1;
            end else begin
              iss_2      = 1'b1;
              in_ready   = 1'b1;
              state_next = S_PAIR;
            end
          end
        end
        default: state_next = S_PAIR;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_PAIR;
    else        state <= state_next;
  end

  logic [2:0]       inc;
  logic [CNT_W-1:0] cnt [0:2];

  assign inc = {dual_inc, split_inc, stall_inc};

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_cnt
      // Saturating event counter: sticks at all-ones.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
          cnt[gi] <= '0;
        else if (inc[gi] && (cnt[gi] != {CNT_W{1'b1}}))
          cnt[gi] <= cnt[gi] + CNT_W'(1);
      end
    end
  endgenerate

  assign stall_cnt = cnt[0];
  assign split_cnt = cnt[1];
  assign dual_cnt  = cnt[2];

endmodule
